reg_file_readout: RTL and testbench

//  Register bank built from enable-gated storage words, plus the read side
//  the datapath lacks: two combinational read ports with write-first bypass,
//  and a sequenced dump engine that streams every word out over a

---
 rtl/reg_file_readout_if.sv | 34 +++
 rtl/reg_file_readout.sv | 124 ++++++++++++
 tb/tb_reg_file_readout.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_readout_if.sv
// Bus bundle for reg_file_readout: write port, two read ports, dump stream.
// Read data is combinational from the addresses; the dump side is registered.
// Dump beats use valid/ready; the producer holds a beat until ready is seen.
interface reg_file_readout_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
);
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [WIDTH-1:0]  WR_DATA;
  logic [ADDR_W-1:0] RD_ADDR_A;
  logic [WIDTH-1:0]  RD_DATA_A;
  logic [ADDR_W-1:0] RD_ADDR_B;
  logic [WIDTH-1:0]  RD_DATA_B;
  logic              DUMP_START;
  logic              DUMP_BUSY;
  logic              DUMP_VALID;
  logic              DUMP_READY;
  logic [ADDR_W-1:0] DUMP_ADDR;
  logic [WIDTH-1:0]  DUMP_DATA;
  logic              DUMP_DONE;

  // Requester side: drives writes, read addresses and the dump controls.
  modport master (
    output WR_EN, WR_ADDR, WR_DATA, RD_ADDR_A, RD_ADDR_B, DUMP_START, DUMP_READY,
    input  RD_DATA_A, RD_DATA_B, DUMP_BUSY, DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
  );

  // Register bank side.
  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, RD_ADDR_A, RD_ADDR_B, DUMP_START, DUMP_READY,
    output RD_DATA_A, RD_DATA_B, DUMP_BUSY, DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
  );
endinterface

// File: rtl/reg_file_readout.sv
// Register bank with two write-first bypassed read ports and a sequenced dump engine.
// Reads: 0 cycles (combinational). Dump: 2 cycles per beat, 2*DEPTH+1 cycles start-to-done.
// Dump holds ADDR/DATA/VALID while DUMP_READY is low; start is ignored while busy.
module reg_file_readout #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic              CLK,
  input logic              RESET_N,
  reg_file_readout_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  // Extra bit so an out-of-range address compares correctly against DEPTH.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  word_q [DEPTH];
  logic [WIDTH-1:0]  word_d [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [WIDTH-1:0]  dump_data_q, dump_data_d;
  logic              wr_live;
  logic [WIDTH-1:0]  load_word;

  // Writes are blocked while reset is held, which also keeps the bypass from
  // leaking write data onto the read ports during reset.
  assign wr_live = bus.WR_EN & RESET_N;

  // Write-first read of one address; out-of-range addresses read 0.
  function automatic logic [WIDTH-1:0] read_word(
    input logic [ADDR_W-1:0] addr,
    input logic [WIDTH-1:0]  stored
  );
    read_word = '0;
    if ({1'b0, addr} < DEPTH_W) begin
      if (wr_live && (bus.WR_ADDR == addr)) read_word = bus.WR_DATA;
      else                                  read_word = stored;
    end
  endfunction

  // Read ports and the dump load word all see the same-cycle write.
  always_comb begin
    bus.RD_DATA_A = read_word(bus.RD_ADDR_A, word_q[bus.RD_ADDR_A]);
    bus.RD_DATA_B = read_word(bus.RD_ADDR_B, word_q[bus.RD_ADDR_B]);
    load_word     = read_word(idx_q, word_q[idx_q]);
  end

  // Next storage contents: only the addressed in-range word changes.
  always_comb begin
    word_d = word_q;
    if (wr_live && ({1'b0, bus.WR_ADDR} < DEPTH_W)) word_d[bus.WR_ADDR] = bus.WR_DATA;
  end

  // Storage words, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) word_q[i] <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Dump sequencer: LOAD captures one word, SEND holds it until accepted.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.DUMP_START) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        dump_addr_d = idx_q;
        dump_data_d = load_word;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (bus.DUMP_READY) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and the held beat; reset aborts any dump in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Stream status decoded straight from the state register.
  always_comb begin
    bus.DUMP_BUSY  = (state_q != S_IDLE);
    bus.DUMP_VALID = (state_q == S_SEND);
    bus.DUMP_DONE  = (state_q == S_DONE);
    bus.DUMP_ADDR  = dump_addr_q;
    bus.DUMP_DATA  = dump_data_q;
  end

endmodule

// File: tb/tb_reg_file_readout.sv
// Directed bench for reg_file_readout: read/write vector table plus dump sequences.
module tb_reg_file_readout;
  localparam int WIDTH  = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  reg_file_readout_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  reg_file_readout #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [WIDTH-1:0]  wd;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [WIDTH-1:0]  ea;
    logic [WIDTH-1:0]  eb;
  } vec_t;
  vec_t vecs [7];

  int b_addr [16];
  int b_data [16];
  int b_vc   [16];
  int held_bad;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      bus.WR_EN   = 1'b1;
      bus.WR_ADDR = ADDR_W'(i);
      bus.WR_DATA = WIDTH'(i + 1);
      step();
    end
    bus.WR_EN = 1'b0;
  endtask

  // Start a dump and collect beats; cycle 1 is the edge that samples START.
  task automatic run_dump(input int stall_beat, input int stall_n, input bit t5,
                          output int nb, output int done_cyc);
    int   stall;
    int   cyc;
    logic rdy;
    for (int i = 0; i < 16; i++) b_vc[i] = 0;
    held_bad = 0;
    nb       = 0;
    done_cyc = -1;
    stall    = stall_n;
    bus.DUMP_START = 1'b1;
    step();
    bus.DUMP_START = 1'b0;
    cyc = 1;
    for (int k = 0; k < 100; k++) begin
      rdy = !(stall > 0 && nb == stall_beat);
      bus.DUMP_READY = rdy;
      bus.WR_EN      = 1'b0;
      if (t5 && bus.DUMP_VALID && bus.DUMP_ADDR == 3'd2) begin
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd6; bus.WR_DATA = 4'd14;
      end
      if (t5 && bus.DUMP_VALID && bus.DUMP_ADDR == 3'd3) begin
        bus.WR_EN = 1'b1; bus.WR_ADDR = 3'd1; bus.WR_DATA = 4'd15;
      end
      if (bus.DUMP_VALID && nb < 16) begin
        if (b_vc[nb] == 0) begin
          b_addr[nb] = int'(bus.DUMP_ADDR);
          b_data[nb] = int'(bus.DUMP_DATA);
        end else if (b_addr[nb] != int'(bus.DUMP_ADDR) || b_data[nb] != int'(bus.DUMP_DATA)) begin
          held_bad++;
        end
        b_vc[nb]++;
        if (rdy) nb++;
        else     stall--;
      end
      if (bus.DUMP_DONE) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    bus.WR_EN      = 1'b0;
    bus.DUMP_READY = 1'b1;
    check("dump_done_seen", int'(done_cyc > 0), 1);
  endtask

  task automatic check_after_done(input string tag);
    step();
    check({tag, "_done_one_cycle"}, int'(bus.DUMP_DONE), 0);
    check({tag, "_busy_low"}, int'(bus.DUMP_BUSY), 0);
  endtask

  initial begin
    int nb;
    int dc;
    bit seen;

    // T1: reset with a write pending
    RESET_N        = 1'b0;
    bus.WR_EN      = 1'b1;
    bus.WR_ADDR    = 3'd3;
    bus.WR_DATA    = 4'd9;
    bus.RD_ADDR_A  = 3'd3;
    bus.RD_ADDR_B  = 3'd0;
    bus.DUMP_START = 1'b0;
    bus.DUMP_READY = 1'b0;
    step();
    step();
    check("t1_rd_a", int'(bus.RD_DATA_A), 0);
    check("t1_busy", int'(bus.DUMP_BUSY), 0);
    check("t1_valid", int'(bus.DUMP_VALID), 0);
    check("t1_done", int'(bus.DUMP_DONE), 0);
    check("t1_addr", int'(bus.DUMP_ADDR), 0);
    check("t1_data", int'(bus.DUMP_DATA), 0);
    bus.WR_EN = 1'b0;
    RESET_N   = 1'b1;
    step();
    check("t1_word3_after", int'(bus.RD_DATA_A), 0);

    // T2: write/read vector table with bypass
    vecs[0] = '{1'b1, 3'd3, 4'd9,  3'd3, 3'd0, 4'd9,  4'd0};
    vecs[1] = '{1'b0, 3'd0, 4'd0,  3'd3, 3'd5, 4'd9,  4'd0};
    vecs[2] = '{1'b1, 3'd3, 4'd10, 3'd2, 3'd3, 4'd0,  4'd10};
    vecs[3] = '{1'b1, 3'd7, 4'd15, 3'd3, 3'd7, 4'd10, 4'd15};
    vecs[4] = '{1'b0, 3'd7, 4'd1,  3'd7, 3'd3, 4'd15, 4'd10};
    vecs[5] = '{1'b1, 3'd0, 4'd5,  3'd0, 3'd7, 4'd5,  4'd15};
    vecs[6] = '{1'b0, 3'd0, 4'd0,  3'd0, 3'd1, 4'd5,  4'd0};
    for (int i = 0; i < 7; i++) begin
      bus.WR_EN     = vecs[i].we;
      bus.WR_ADDR   = vecs[i].wa;
      bus.WR_DATA   = vecs[i].wd;
      bus.RD_ADDR_A = vecs[i].ra;
      bus.RD_ADDR_B = vecs[i].rb;
      #1;
      check($sformatf("t2_vec%0d_a", i), int'(bus.RD_DATA_A), int'(vecs[i].ea));
      check($sformatf("t2_vec%0d_b", i), int'(bus.RD_DATA_B), int'(vecs[i].eb));
      step();
    end
    bus.WR_EN = 1'b0;

    // T3: full dump with READY always high
    preload();
    bus.DUMP_READY = 1'b1;
    run_dump(-1, 0, 1'b0, nb, dc);
    check("t3_beats", nb, 8);
    check("t3_done_cycle", dc, 17);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_beat%0d_addr", i), b_addr[i], i);
      check($sformatf("t3_beat%0d_data", i), b_data[i], i + 1);
      check($sformatf("t3_beat%0d_vcycles", i), b_vc[i], 1);
    end
    check_after_done("t3");

    // T4: three-cycle stall on beat 2
    run_dump(2, 3, 1'b0, nb, dc);
    check("t4_beats", nb, 8);
    check("t4_done_cycle", dc, 20);
    check("t4_held_stable", held_bad, 0);
    check("t4_beat2_vcycles", b_vc[2], 4);
    check("t4_beat2_data", b_data[2], 3);
    for (int i = 0; i < 8; i++) check($sformatf("t4_beat%0d_addr", i), b_addr[i], i);
    check_after_done("t4");

    // T5: writes during a dump
    run_dump(-1, 0, 1'b1, nb, dc);
    check("t5_beats", nb, 8);
    check("t5_beat6_data", b_data[6], 14);
    check("t5_beat1_data", b_data[1], 2);
    check("t5_beat7_addr", b_addr[7], 7);
    check("t5_done_cycle", dc, 17);
    bus.RD_ADDR_A = 3'd1;
    bus.RD_ADDR_B = 3'd6;
    #1;
    check("t5_word1", int'(bus.RD_DATA_A), 15);
    check("t5_word6", int'(bus.RD_DATA_B), 14);
    step();

    // T6: reset while beat 4 is valid
    bus.DUMP_READY = 1'b1;
    bus.DUMP_START = 1'b1;
    step();
    bus.DUMP_START = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.DUMP_VALID && bus.DUMP_ADDR == 3'd4) seen = 1'b1;
      else step();
    end
    check("t6_beat4_reached", int'(seen), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t6_valid_async", int'(bus.DUMP_VALID), 0);
    check("t6_busy_async", int'(bus.DUMP_BUSY), 0);
    check("t6_done_async", int'(bus.DUMP_DONE), 0);
    check("t6_data_async", int'(bus.DUMP_DATA), 0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.RD_ADDR_A = ADDR_W'(i);
      step();
      check($sformatf("t6_word%0d_zero", i), int'(bus.RD_DATA_A), 0);
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_done_after_abort", int'(bus.DUMP_DONE), 0);
    end
    run_dump(-1, 0, 1'b0, nb, dc);
    check("t6_beats", nb, 8);
    check("t6_done_cycle", dc, 17);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t6_beat%0d_addr", i), b_addr[i], i);
      check($sformatf("t6_beat%0d_data", i), b_data[i], 0);
    end
    check_after_done("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
